// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: write-domain pointer/status controller of the asynchronous FIFO (optional overflow logic under FIFO_WR_OVF_EN).
// Latency: w_en_o/w_addr_o combinational from w_inc_i and the pointer; pointers, full, level, almost-full update one edge after the cause.
// Backpressure: writes are rejected while w_full_o is high; w_full_o clears only once the synchronised read pointer shows free space.
module fifo_write_ctrl #(
   parameter int ADDR_SIZE    = 8,
   parameter int AFULL_THRESH = 252
) (
   input  logic                 w_clk_i,
   input  logic                 w_rst_i,
   input  logic                 w_inc_i,
   input  logic [ADDR_SIZE:0]   w_r_ptr_i,
   output logic [ADDR_SIZE-1:0] w_addr_o,
   output logic                 w_en_o,
   output logic [ADDR_SIZE:0]   w_ptr_o,
   output logic                 w_full_o,
   output logic                 w_almost_full_o,
   output logic [ADDR_SIZE:0]   w_level_o,
   input  logic                 w_ovf_clr_i,
   output logic                 w_ovf_o,
   output logic [15:0]          w_ovf_cnt_o
);

   localparam int PW = ADDR_SIZE + 1;
   localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

   logic [PW-1:0] w_bin;
   logic [PW-1:0] w_gray;
   logic [PW-1:0] bin_next;
   logic [PW-1:0] gray_next;
   logic [PW-1:0] r_bin;
   logic [PW-1:0] level_next;
   logic          full_next;
   logic          almost_full_next;
   logic          accept;

   // A write is taken only when there is room; while reset is held nothing is written,
   // so an in-flight request during reset never reaches the RAM.
   assign accept   = w_inc_i && !w_full_o && w_rst_i;
   assign w_en_o   = accept;
   assign w_addr_o = w_bin[ADDR_SIZE-1:0];
   assign w_ptr_o  = w_gray;

   // Next pointer in both codes; the extra MSB distinguishes full from empty.
   assign bin_next  = w_bin + PW'(accept);
   assign gray_next = (bin_next >> 1) ^ bin_next;

   // Gray-to-binary of the synchronised read pointer: each bit is the XOR of itself and all bits above.
   always_comb begin
      r_bin = '0;
      for (int i = 0; i < PW; i++) begin
         r_bin[i] = ^(w_r_ptr_i >> i);
      end
   end

   // Full when the write pointer has lapped the read pointer exactly once; level and
   // almost-full share the same next pointer so all three flags always agree.
   assign full_next        = (gray_next == {~w_r_ptr_i[ADDR_SIZE:ADDR_SIZE-1],
                                            w_r_ptr_i[ADDR_SIZE-2:0]});
   assign level_next       = bin_next - r_bin;
   assign almost_full_next = (level_next >= AFULL_LVL);

   // Pointer and status registers.
   always_ff @(posedge w_clk_i or negedge w_rst_i) begin
      if (!w_rst_i) begin
         w_bin           <= '0;
         w_gray          <= '0;
         w_full_o        <= 1'b0;
         w_almost_full_o <= 1'b0;
         w_level_o       <= '0;
      end else begin
         w_bin           <= bin_next;
         w_gray          <= gray_next;
         w_full_o        <= full_next;
         w_almost_full_o <= almost_full_next;
         w_level_o       <= level_next;
      end
   end

`ifdef FIFO_WR_OVF_EN
   // Sticky flag and saturating count of writes attempted while full; a clear beats a same-cycle overflow.
   always_ff @(posedge w_clk_i or negedge w_rst_i) begin
      if (!w_rst_i) begin
         w_ovf_o     <= 1'b0;
         w_ovf_cnt_o <= '0;
      end else if (w_ovf_clr_i) begin
         w_ovf_o     <= 1'b0;
         w_ovf_cnt_o <= '0;
      end else if (w_inc_i && w_full_o) begin
         w_ovf_o <= 1'b1;
         if (w_ovf_cnt_o != 16'hFFFF) begin
            w_ovf_cnt_o <= w_ovf_cnt_o + 16'd1;
         end
      end
   end
`else
   assign w_ovf_o     = 1'b0;
   assign w_ovf_cnt_o = '0;
   logic unused_ovf_clr;
   assign unused_ovf_clr = w_ovf_clr_i;
`endif

endmodule
